// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter that lets the CPU memory port (requester 0)
// and the debug/loader port (requester 1) share one single-port synchronous
// memory. Each single-word access takes three cycles: IDLE (arbitrate and
// latch), ACC (drive the memory), ACK (return data and pulse ack).
module mem_arb #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic [AW-1:0] mem_adr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACC, ACK} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          last;
  logic          owner_q;
  logic          lat_we;
  logic [AW-1:0] lat_adr;
  logic [DW-1:0] lat_wdata;
  logic          any_req;
  logic          winner;
  logic          ack_phase;

  assign any_req = m0_req | m1_req;

  // Pick the winner: a lone requester wins, a tie goes to whoever was not served last
  always_comb begin
    winner = 1'b0;
    if (m0_req && m1_req) begin
      winner = ~last;
    end else if (m1_req) begin
      winner = 1'b1;
    end
  end

  // Next-state logic: IDLE waits for a request, ACC and ACK each last one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACC;
      ACC:     state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch the winning request in IDLE so later input changes cannot disturb the access
  always_ff @(posedge clk) begin
    if (rst) begin
      last      <= 1'b1;
      owner_q   <= 1'b0;
      lat_we    <= 1'b0;
      lat_adr   <= '0;
      lat_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_q   <= winner;
            lat_we    <= winner ? m1_we    : m0_we;
            lat_adr   <= winner ? m1_adr   : m0_adr;
            lat_wdata <= winner ? m1_wdata : m0_wdata;
          end
        end
        ACK: begin
          last    <= owner_q;
          owner_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // A reset landing in ACC or ACK must neither write memory nor acknowledge
  assign ack_phase = (state == ACK) && !rst;

  assign mem_adr   = lat_adr;
  assign mem_wdata = lat_wdata;
  assign mem_we    = (state == ACC) && lat_we && !rst;

  assign m0_ack    = ack_phase && !owner_q;
  assign m1_ack    = ack_phase &&  owner_q;
  assign m0_rdata  = m0_ack ? mem_rdata : '0;
  assign m1_rdata  = m1_ack ? mem_rdata : '0;

  assign owner     = owner_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: scoreboard bench for mem_arb with a behavioural synchronous memory.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 0, m0_we = 0;
  logic [31:0] m0_adr = 0, m0_wdata = 0;
  logic [31:0] m0_rdata;
  logic        m0_ack;
  logic        m1_req = 0, m1_we = 0;
  logic [31:0] m1_adr = 0, m1_wdata = 0;
  logic [31:0] m1_rdata;
  logic        m1_ack;
  logic [31:0] mem_adr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic        owner;
  logic        busy;

  logic [31:0] mem [0:255];
  logic        mem_init = 1'b1;

  typedef struct {
    bit          who;
    bit          chk;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int we_cnt = 0;
  logic [31:0] we_adr = 0, we_data = 0;
  logic prev_m0_ack = 0, prev_m1_ack = 0;

  mem_arb #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .mem_adr(mem_adr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory: one-cycle read latency, write on mem_we
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h30] <= 32'hCAFEF00D;
      mem[8'h40] <= 32'h0BADF00D;
    end else if (mem_we) begin
      mem[mem_adr[7:0]] <= mem_wdata;
    end
    mem_rdata <= mem[mem_adr[7:0]];
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Ack monitor: pops the scoreboard on every ack and checks requester and data
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        we_cnt++;
        we_adr  = mem_adr;
        we_data = mem_wdata;
      end
      if (m0_ack || m1_ack) begin
        checkOutput("both_ack", {31'b0, m0_ack && m1_ack}, 32'd0);
        checkOutput("double_ack", {31'b0, (m0_ack && prev_m0_ack) || (m1_ack && prev_m1_ack)}, 32'd0);
        if (sb.size() == 0) begin
          checkOutput("spurious_ack", {31'b0, m1_ack}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("ack_who", {31'b0, m1_ack}, {31'b0, e.who});
          if (e.chk) checkOutput("rdata", e.who ? m1_rdata : m0_rdata, e.data);
          checkOutput("other_rdata", e.who ? m0_rdata : m1_rdata, 32'd0);
        end
      end
    end
    prev_m0_ack = m0_ack;
    prev_m1_ack = m1_ack;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit who, input bit req, input bit we,
                               input logic [31:0] adr, input logic [31:0] wdata);
    if (who) begin
      m1_req = req; m1_we = we; m1_adr = adr; m1_wdata = wdata;
    end else begin
      m0_req = req; m0_we = we; m0_adr = adr; m0_wdata = wdata;
    end
  endtask

  task automatic push_exp(input bit who, input bit chk, input logic [31:0] data);
    exp_t e;
    e.who = who; e.chk = chk; e.data = data;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    step(); step();
    rst = 1'b0;
  endtask

  // Wait for n acks within a cycle budget, optionally dropping each winner's req
  task automatic wait_acks(input int n, input bit drop);
    int got = 0;
    for (int c = 0; c < 40 && got < n; c++) begin
      step();
      if (m0_ack) begin got++; if (drop) m0_req = 1'b0; end
      if (m1_ack) begin got++; if (drop) m1_req = 1'b0; end
    end
    checkOutput("ack_count", got, n);
  endtask

  // One full transaction with latency and ACC-phase address checks
  task automatic run_txn(input bit who, input bit we, input logic [31:0] adr,
                         input logic [31:0] wdata, input logic [31:0] exp_data);
    int lat = 0;
    bit seen = 0;
    push_exp(who, !we, exp_data);
    applyStimulus(who, 1, we, adr, wdata);
    for (int c = 1; c <= 10 && !seen; c++) begin
      step();
      if (c == 1) begin
        checkOutput("acc_adr", mem_adr, adr);
        checkOutput("acc_busy", {31'b0, busy}, 32'd1);
        checkOutput("acc_owner", {31'b0, owner}, {31'b0, who});
      end
      if (who ? m1_ack : m0_ack) begin seen = 1; lat = c; end
    end
    checkOutput("ack_latency", lat, 2);
    applyStimulus(who, 0, we, adr, wdata);
    step();
  endtask

  initial begin
    int got, last_cyc, wcnt0;
    logic [31:0] tie_adr0, tie_adr1;
    bit exp_order [4];

    $display("[TB] mem_arb bench start");
    step();
    mem_init = 1'b0;
    do_reset();

    // reset values
    checkOutput("rst_owner", {31'b0, owner}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_mem_we", {31'b0, mem_we}, 32'd0);
    checkOutput("rst_mem_adr", mem_adr, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_acks", {30'b0, m0_ack, m1_ack}, 32'd0);
    checkOutput("rst_rdata", m0_rdata | m1_rdata, 32'd0);

    // single read by requester 0
    run_txn(0, 0, 32'h10, 32'h0, 32'hDEADBEEF);

    // single write by requester 1, then read back by requester 0
    wcnt0 = we_cnt;
    run_txn(1, 1, 32'h20, 32'h12345678, 32'h0);
    checkOutput("we_cycles", we_cnt - wcnt0, 1);
    checkOutput("we_adr", we_adr, 32'h20);
    checkOutput("we_data", we_data, 32'h12345678);
    run_txn(0, 0, 32'h20, 32'h0, 32'h12345678);
    checkOutput("idle_mem_we", {31'b0, mem_we}, 32'd0);
    checkOutput("idle_owner", {31'b0, owner}, 32'd0);

    // simultaneous requests held high: strict alternation starting with 0
    do_reset();
    exp_order = '{0, 1, 0, 1};
    tie_adr0 = 32'h10;
    tie_adr1 = 32'h20;
    for (int k = 0; k < 4; k++) push_exp(exp_order[k], 1, exp_order[k] ? 32'h12345678 : 32'hDEADBEEF);
    applyStimulus(0, 1, 0, tie_adr0, 0);
    applyStimulus(1, 1, 0, tie_adr1, 0);
    got = 0;
    last_cyc = 0;
    for (int c = 1; c <= 30 && got < 4; c++) begin
      step();
      if (m0_ack || m1_ack) begin
        checkOutput("tie_owner", {31'b0, owner}, {31'b0, exp_order[got]});
        if (got > 0) checkOutput("ack_period", {31'b0, (c - last_cyc) >= 3 && (c - last_cyc) <= 4}, 32'd1);
        last_cyc = c;
        got++;
      end
    end
    checkOutput("tie_acks", got, 4);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    step(); step();
    checkOutput("tie_idle_busy", {31'b0, busy}, 32'd0);

    // address change during ACC is ignored
    push_exp(0, 1, 32'hDEADBEEF);
    applyStimulus(0, 1, 0, 32'h10, 0);
    step();
    checkOutput("mid_acc_adr", mem_adr, 32'h10);
    m0_adr = 32'h30;
    step();
    checkOutput("mid_ack_adr", mem_adr, 32'h10);
    checkOutput("mid_ack", {31'b0, m0_ack}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0);
    step(); step();

    // reset during ACC of a write to 0x40
    wcnt0 = we_cnt;
    applyStimulus(1, 1, 1, 32'h40, 32'h55555555);
    step();
    rst = 1'b1;
    applyStimulus(1, 0, 0, 0, 0);
    #1;
    checkOutput("rst_acc_mem_we", {31'b0, mem_we}, 32'd0);
    checkOutput("rst_acc_ack", {30'b0, m0_ack, m1_ack}, 32'd0);
    step();
    rst = 1'b0;
    checkOutput("rst_acc_busy", {31'b0, busy}, 32'd0);
    step(); step(); step();
    checkOutput("rst_acc_mem40", mem[8'h40], 32'h0BADF00D);
    checkOutput("rst_acc_we_cnt", we_cnt - wcnt0, 0);
    push_exp(0, 1, 32'hDEADBEEF);
    push_exp(1, 1, 32'h12345678);
    applyStimulus(0, 1, 0, 32'h10, 0);
    applyStimulus(1, 1, 0, 32'h20, 0);
    wait_acks(2, 1);
    step(); step();

    // requester holds req one cycle past ack: exactly one repeat transaction
    push_exp(0, 1, 32'hCAFEF00D);
    push_exp(0, 1, 32'hCAFEF00D);
    applyStimulus(0, 1, 0, 32'h30, 0);
    wait_acks(1, 0);
    step(); step();
    applyStimulus(0, 0, 0, 32'h30, 0);
    wait_acks(1, 0);
    step(); step(); step(); step();

    checkOutput("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
